// File: rtl/rotator_step_fsm.sv
// rtl/rotator_step_fsm.sv - rotation position generator for the seven-segment square spinner
//
// Purpose:
//   Divides clk by TICK_DIV into a step tick and moves a 3-bit rotation
//   position one place per tick. The direction is clockwise (+1) or
//   counter-clockwise (-1). Positions 0-3 are upper squares and 4-7 are
//   lower squares in the downstream position decoder.
//
// Optional feature:
//   INPUT_SYNC_EN - when defined, en and cw each pass through a 2-flop
//   synchroniser (reset to 0) before use, which adds 2 cycles of
//   input-to-effect latency. When undefined, en and cw are used directly.
//
// Ports:
//   clk    in   1  board clock, all logic on posedge
//   rst    in   1  synchronous active-high reset
//   en     in   1  run enable (switch level)
//   cw     in   1  direction: 1 = increment, 0 = decrement
//   state  out  3  current rotation position 0..7, registered
//   step   out  1  one-cycle pulse in the first cycle a new state is visible

module rotator_step_fsm #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       cw,
  output logic [2:0] state,
  output logic       step
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic en_i;
  logic cw_i;

`ifdef INPUT_SYNC_EN
  logic en_s1_q, en_s1_d;
  logic en_s2_q, en_s2_d;
  logic cw_s1_q, cw_s1_d;
  logic cw_s2_q, cw_s2_d;

  always_comb begin
    en_s1_d = en;
    en_s2_d = en_s1_q;
    cw_s1_d = cw;
    cw_s2_d = cw_s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_s1_q <= 1'b0;
      en_s2_q <= 1'b0;
      cw_s1_q <= 1'b0;
      cw_s2_q <= 1'b0;
    end else begin
      en_s1_q <= en_s1_d;
      en_s2_q <= en_s2_d;
      cw_s1_q <= cw_s1_d;
      cw_s2_q <= cw_s2_d;
    end
  end

  assign en_i = en_s2_q;
  assign cw_i = cw_s2_q;
`else
  assign en_i = en;
  assign cw_i = cw;
`endif

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [2:0]       state_q, state_d;
  logic             step_q, step_d;
  logic             tick;

  always_comb begin
    // Dropping en on the terminal count suppresses the tick, and the
    // partial count is discarded so the next run starts a full period.
    tick       = en_i && (tick_cnt_q == CNT_LAST);
    tick_cnt_d = tick_cnt_q;
    state_d    = state_q;
    step_d     = tick;

    if (!en_i) begin
      tick_cnt_d = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end

    // Direction is only looked at on the tick edge; mod-8 wrap comes
    // from the 3-bit arithmetic.
    if (tick) begin
      if (cw_i) begin
        state_d = state_q + 3'd1;
      end else begin
        state_d = state_q - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= '0;
      state_q    <= 3'd0;
      step_q     <= 1'b0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      step_q     <= step_d;
    end
  end

  assign state = state_q;
  assign step  = step_q;

endmodule
